// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Register-file write-port arbiter. The W-stage write always
//               wins the port. Results from the long-latency unit (mul/div)
//               are parked in a 2-entry FIFO and drained into free
//               write-back slots in acceptance order. A query port reports
//               pending destinations so that RAW hazards can be detected. A
//               starvation counter raises stall so that upstream control can
//               open a free slot.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        wwreg,
    input  logic [4:0]  wrn,
    input  logic [31:0] wdi,
    input  logic        lreq,
    input  logic [4:0]  lrn,
    input  logic [31:0] ldata,
    output logic        lack,
    input  logic [4:0]  qrn,
    output logic        qhit,
    output logic        rf_we,
    output logic [4:0]  rf_wn,
    output logic [31:0] rf_d,
    output logic        stall
);

    localparam logic [1:0] FIFO_FULL = 2'd2;
    localparam logic [2:0] STARV_MAX = 3'd7;

    // FIFO storage and bookkeeping
    logic [4:0]  rn_q   [0:1];
    logic [31:0] data_q [0:1];
    logic        head_q;
    logic        tail_q;
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic [2:0]  starv_q;
    logic [2:0]  starv_d;
    logic        stall_q;

    logic        w_slot_busy;
    logic        w_enq;
    logic        w_pop;
    logic        w_hit_head;
    logic        w_hit_next;

    // A write to r0 is a no-op, so it does not occupy the port.
    assign w_slot_busy = wwreg & (wrn != 5'd0);

    // Accept whenever there is room. Results for r0 are acknowledged but
    // never stored.
    assign lack  = lreq & (count_q != FIFO_FULL) & ~reset;
    assign w_enq = lack & (lrn != 5'd0);

    // The head drains only into a slot the pipeline leaves free.
    assign w_pop = ~reset & ~w_slot_busy & (count_q != 2'd0);

    // Hazard query covers stored entries only, never the incoming request.
    assign w_hit_head = (count_q != 2'd0) & (rn_q[head_q] == qrn);
    assign w_hit_next = (count_q == FIFO_FULL) & (rn_q[~head_q] == qrn);
    assign qhit       = ~reset & (qrn != 5'd0) & (w_hit_head | w_hit_next);

    assign stall = stall_q;

    // Write-port mux: pipeline first, then FIFO head, otherwise idle zeros.
    always_comb begin
        rf_we = 1'b0;
        rf_wn = 5'd0;
        rf_d  = 32'd0;
        if (!reset) begin
            if (w_slot_busy) begin
                rf_we = 1'b1;
                rf_wn = wrn;
                rf_d  = wdi;
            end else if (count_q != 2'd0) begin
                rf_we = 1'b1;
                rf_wn = rn_q[head_q];
                rf_d  = data_q[head_q];
            end
        end
    end

    // Next occupancy. A simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({w_enq, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Starvation: count the cycles in which queued data is blocked by the
    // pipeline. Any drain, or an empty FIFO, restarts the count.
    always_comb begin
        starv_d = starv_q;
        if (w_pop || (count_q == 2'd0)) begin
            starv_d = 3'd0;
        end else if (w_slot_busy) begin
            starv_d = (starv_q == STARV_MAX) ? STARV_MAX : starv_q + 3'd1;
        end
    end

    // Payload capture at the tail. No reset is needed because validity is
    // tracked by count.
    always_ff @(posedge clock) begin
        if (w_enq) begin
            rn_q[tail_q]   <= lrn;
            data_q[tail_q] <= ldata;
        end
    end

    // Pointers wrap naturally at one bit. Stall is registered from the
    // counter value that is about to be stored.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
            starv_q <= 3'd0;
            stall_q <= 1'b0;
        end else begin
            head_q  <= head_q ^ w_pop;
            tail_q  <= tail_q ^ w_enq;
            count_q <= count_d;
            starv_q <= starv_d;
            stall_q <= (starv_d == STARV_MAX);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Self-checking bench for wb_port_arbiter. A queue-based model
//               predicts every output in every cycle. The bench runs directed
//               scenarios first and then a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        wwreg;
    logic [4:0]  wrn;
    logic [31:0] wdi;
    logic        lreq;
    logic [4:0]  lrn;
    logic [31:0] ldata;
    logic        lack;
    logic [4:0]  qrn;
    logic        qhit;
    logic        rf_we;
    logic [4:0]  rf_wn;
    logic [31:0] rf_d;
    logic        stall;

    wb_port_arbiter dut (
        .clock (clock),
        .reset (reset),
        .wwreg (wwreg),
        .wrn   (wrn),
        .wdi   (wdi),
        .lreq  (lreq),
        .lrn   (lrn),
        .ldata (ldata),
        .lack  (lack),
        .qrn   (qrn),
        .qhit  (qhit),
        .rf_we (rf_we),
        .rf_wn (rf_wn),
        .rf_d  (rf_d),
        .stall (stall)
    );

    always #5 clock = ~clock;

    // Reference model state: pending results in acceptance order
    typedef struct {
        logic [4:0]  rn;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    int   m_starv = 0;
    bit   m_stall = 1'b0;

    int   n_assert = 0;
    int   n_fail   = 0;

    // Outputs observed in the most recent cycle, kept for directed checks
    logic        obs_lack, obs_qhit, obs_we, obs_stall;
    logic [4:0]  obs_wn;
    logic [31:0] obs_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle. Called at a negedge: drive the inputs, let them
    // settle, compare against the model, then advance the model at the
    // posedge.
    task automatic cycle(input logic rs, input logic ww, input logic [4:0] wn,
                         input logic [31:0] wd, input logic lr, input logic [4:0] ln,
                         input logic [31:0] ld, input logic [4:0] qn);
        bit          busy, e_lack, e_qhit, e_we, pop;
        logic [4:0]  e_wn;
        logic [31:0] e_d;
        int          sz;
        reset = rs; wwreg = ww; wrn = wn; wdi = wd;
        lreq = lr; lrn = ln; ldata = ld; qrn = qn;
        #2;
        sz     = q.size();
        busy   = ww && (wn != 5'd0);
        e_lack = !rs && lr && (sz < 2);
        e_qhit = 1'b0;
        if (!rs && qn != 5'd0)
            foreach (q[k]) if (q[k].rn == qn) e_qhit = 1'b1;
        e_we = 1'b0; e_wn = 5'd0; e_d = 32'd0;
        if (!rs && busy) begin
            e_we = 1'b1; e_wn = wn; e_d = wd;
        end else if (!rs && sz > 0) begin
            e_we = 1'b1; e_wn = q[0].rn; e_d = q[0].d;
        end
        obs_lack = lack; obs_qhit = qhit; obs_we = rf_we;
        obs_wn = rf_wn; obs_d = rf_d; obs_stall = stall;
        check("lack",  lack,  e_lack);
        check("qhit",  qhit,  e_qhit);
        check("rf_we", rf_we, e_we);
        check("rf_wn", rf_wn, e_wn);
        check("rf_d",  rf_d,  e_d);
        check("stall", stall, m_stall);
        @(posedge clock);
        if (rs) begin
            q.delete();
            m_starv = 0;
            m_stall = 1'b0;
        end else begin
            pop = !busy && (sz > 0);
            if (pop) void'(q.pop_front());
            if (e_lack && ln != 5'd0) q.push_back('{rn: ln, d: ld});
            if (pop || sz == 0) m_starv = 0;
            else if (busy) m_starv = (m_starv < 7) ? m_starv + 1 : 7;
            m_stall = (m_starv == 7);
        end
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; wwreg = 1'b0; wrn = '0; wdi = '0;
        lreq = 1'b0; lrn = '0; ldata = '0; qrn = '0;
        @(posedge clock); @(posedge clock); @(negedge clock);

        // While reset is held, outputs are forced low even with live inputs.
        cycle(1, 1, 5'd3, 32'hDEAD_BEEF, 1, 5'd4, 32'h1, 5'd4);
        check("rst_we", obs_we, 1'b0);

        // Single accept with no bypass, one-cycle write-back and the qhit window
        cycle(0, 0, 5'd0, 32'd0, 1, 5'd5, 32'h1234, 5'd5);
        check("acc_lack", obs_lack, 1'b1);
        check("acc_nobypass", obs_we, 1'b0);
        cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd5);
        check("wb_wn", obs_wn, 5'd5);
        check("wb_d", obs_d, 32'h1234);
        check("wb_qhit", obs_qhit, 1'b1);
        cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd5);
        check("post_qhit", obs_qhit, 1'b0);

        // Busy slot with three back-to-back requests: the third finds the FIFO full.
        cycle(0, 1, 5'd3, 32'hA0, 1, 5'd4, 32'h44, 5'd0);
        check("fill_lack0", obs_lack, 1'b1);
        cycle(0, 1, 5'd3, 32'hA1, 1, 5'd6, 32'h66, 5'd0);
        check("fill_lack1", obs_lack, 1'b1);
        cycle(0, 1, 5'd3, 32'hA2, 1, 5'd7, 32'h77, 5'd6);
        check("fill_lack2", obs_lack, 1'b0);
        check("fill_wn", obs_wn, 5'd3);

        // Keep the slot busy so that the starvation counter saturates.
        for (int i = 0; i < 7; i++)
            cycle(0, 1, 5'd3, 32'hB0 + i, 0, 5'd0, 32'd0, 5'd4);
        check("starve_stall", obs_stall, 1'b1);
        cycle(0, 1, 5'd3, 32'hC0, 0, 5'd0, 32'd0, 5'd0);
        check("stall_reassert", obs_stall, 1'b1);
        cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0);
        check("starve_pop_wn", obs_wn, 5'd4);

        // Count is 1: drain the head and accept 9 in the same cycle.
        cycle(0, 0, 5'd0, 32'd0, 1, 5'd9, 32'h999, 5'd9);
        check("swap_stall_clr", obs_stall, 1'b0);
        check("swap_wn", obs_wn, 5'd6);
        check("swap_qhit", obs_qhit, 1'b0);
        cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0);
        check("swap_next_wn", obs_wn, 5'd9);

        // A result for r0 is acked but dropped. A write to r0 leaves the slot free.
        cycle(0, 1, 5'd2, 32'h22, 1, 5'd11, 32'hBB, 5'd0);
        cycle(0, 1, 5'd0, 32'h55, 1, 5'd0, 32'hCC, 5'd11);
        check("r0_lack", obs_lack, 1'b1);
        check("r0_drain_wn", obs_wn, 5'd11);
        cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0);
        check("r0_nowrite", obs_we, 1'b0);

        // Reset with a full FIFO: nothing stale emerges afterwards.
        cycle(0, 1, 5'd1, 32'h11, 1, 5'd12, 32'h120, 5'd0);
        cycle(0, 1, 5'd1, 32'h12, 1, 5'd13, 32'h130, 5'd0);
        cycle(1, 1, 5'd3, 32'h33, 1, 5'd14, 32'h140, 5'd12);
        check("midrst_lack", obs_lack, 1'b0);
        check("midrst_qhit", obs_qhit, 1'b0);
        cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd12);
        check("postrst_we", obs_we, 1'b0);
        check("postrst_qhit", obs_qhit, 1'b0);

        // Randomized phase that alternates mostly-busy and mostly-free stretches
        for (int i = 0; i < 600; i++) begin
            logic        rs, ww, lr;
            logic [4:0]  wn, ln, qn;
            int          busy_pct;
            busy_pct = ((i / 40) % 2 == 1) ? 95 : 40;
            rs = ($urandom_range(0, 59) == 0);
            ww = ($urandom_range(0, 99) < busy_pct);
            wn = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            lr = ($urandom_range(0, 99) < 55);
            ln = 5'($urandom_range(0, 7));
            qn = 5'($urandom_range(0, 7));
            cycle(rs, ww, wn, $urandom, lr, ln, $urandom, qn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
